// File: rtl/piso_shifter_if.sv
// ---------------------------------------------------------------------------
// piso_shifter_if
// Purpose : bundles the parallel-load handshake, the serial output handshake
//           and the status flags of piso_shifter into one interface.
// Ports   : load_valid/load_ready/load_data : parallel word handshake
//           ser_out/ser_valid/ser_ready      : serial bit handshake
//           busy/done                        : status flags
// Modports: master = the side that offers words and consumes bits
//           slave  = the shifter itself
// ---------------------------------------------------------------------------
interface piso_shifter_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_ready;
   logic             busy;
   logic             done;

   modport master (
      output load_valid, load_data, ser_ready,
      input  load_ready, ser_out, ser_valid, busy, done
   );

   modport slave (
      input  load_valid, load_data, ser_ready,
      output load_ready, ser_out, ser_valid, busy, done
   );
endinterface

// File: rtl/piso_shifter.sv
// ---------------------------------------------------------------------------
// piso_shifter
// Purpose : parallel-in / serial-out shifter with valid/ready handshakes on
//           both the parallel load side and the serial output side.
// Params  : WIDTH     - data bits per word (2..32)
//           MSB_FIRST - 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset
//           bus - piso_shifter_if.slave (load_*, ser_*, busy, done)
// Config  : define PISO_PARITY_EN to append an even-parity bit after each
//           word (PAR state); undefined gives WIDTH transfers per word.
// ---------------------------------------------------------------------------
module piso_shifter #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   piso_shifter_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_PAR   = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
   } state_t;
`endif

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shreg_shifted;
   logic [CW-1:0]    r_cnt;
   logic             r_done;
`ifdef PISO_PARITY_EN
   logic             r_par;
`endif

   logic w_load_ready;
   logic w_ser_valid;
   logic w_ser_out;
   logic w_busy;
   logic w_load_hs;
   logic w_xfer;
   logic w_last_bit;
   logic w_word_end;

   assign w_load_hs  = bus.load_valid && w_load_ready;
   assign w_xfer     = w_ser_valid && bus.ser_ready;
   assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; also flags the transfer that completes a word
   always_comb begin
      w_next_state = r_state;
      w_word_end   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_load_hs) begin
               w_next_state = S_SHIFT;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (w_xfer && w_last_bit) begin
`ifdef PISO_PARITY_EN
               w_next_state = S_PAR;
`else
               w_next_state = S_IDLE;
               w_word_end   = 1'b1;
`endif
            end else begin
               w_next_state = S_SHIFT;
            end
         end
`ifdef PISO_PARITY_EN
         S_PAR: begin
            if (w_xfer) begin
               w_next_state = S_IDLE;
               w_word_end   = 1'b1;
            end else begin
               w_next_state = S_PAR;
            end
         end
`endif
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Output decode from state and datapath registers
   always_comb begin
      w_load_ready = 1'b0;
      w_ser_valid  = 1'b0;
      w_ser_out    = 1'b0;
      w_busy       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_load_ready = 1'b1;
         end
         S_SHIFT: begin
            w_ser_valid = 1'b1;
            w_busy      = 1'b1;
            if (MSB_FIRST) begin
               w_ser_out = r_shreg[WIDTH-1];
            end else begin
               w_ser_out = r_shreg[0];
            end
         end
`ifdef PISO_PARITY_EN
         S_PAR: begin
            w_ser_valid = 1'b1;
            w_busy      = 1'b1;
            w_ser_out   = r_par;
         end
`endif
         default: begin
            w_load_ready = 1'b0;
         end
      endcase
   end

   // Shift toward the output end with zero fill
   always_comb begin
      if (MSB_FIRST) begin
         w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
      end else begin
         w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
      end
   end

   // Datapath: capture on load, shift on transfer, hold on stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg <= {WIDTH{1'b0}};
         r_cnt   <= {CW{1'b0}};
         r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         // done is registered so it appears the cycle after the final transfer
         r_done <= w_word_end;
         if (w_load_hs) begin
            r_shreg <= bus.load_data;
            r_cnt   <= {CW{1'b0}};
`ifdef PISO_PARITY_EN
            r_par   <= ^bus.load_data;
`endif
         end else if ((r_state == S_SHIFT) && w_xfer) begin
            r_shreg <= w_shreg_shifted;
            r_cnt   <= r_cnt + CW'(1);
         end else begin
            r_shreg <= r_shreg;
            r_cnt   <= r_cnt;
         end
      end
   end

   assign bus.load_ready = w_load_ready;
   assign bus.ser_valid  = w_ser_valid;
   assign bus.ser_out    = w_ser_out;
   assign bus.busy       = w_busy;
   assign bus.done       = r_done;

endmodule

// File: tb/tb_piso_shifter.sv
// ---------------------------------------------------------------------------
// tb_piso_shifter
// Purpose : directed self-checking bench for piso_shifter. One instance is
//           MSB-first (bus m), one LSB-first (bus l); both share clk/rst.
// ---------------------------------------------------------------------------
module tb_piso_shifter;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   piso_shifter_if #(.WIDTH(8)) m ();
   piso_shifter_if #(.WIDTH(8)) l ();

   piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk (clk),
      .rst (rst),
      .bus (m.slave)
   );

   piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk (clk),
      .rst (rst),
      .bus (l.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // seq[7] is the first expected serial bit; ready held at 1.
   // intrude: offer a different word mid-stream that must be ignored.
   task automatic shift_word_m(input string name, input logic [7:0] seq, input logic par,
                               input bit intrude);
      for (int i = 0; i < 8; i++) begin
         if (intrude && i == 2) begin
            m.load_valid = 1'b1;
            m.load_data  = 8'hFF;
         end
         if (intrude && i == 7) begin
            m.load_valid = 1'b0;
         end
         chk($sformatf("%s_valid%0d", name, i), m.ser_valid, 1'b1);
         chk($sformatf("%s_bit%0d", name, i), m.ser_out, seq[7-i]);
         chk($sformatf("%s_lready%0d", name, i), m.load_ready, 1'b0);
         chk($sformatf("%s_busy%0d", name, i), m.busy, 1'b1);
         chk($sformatf("%s_done%0d", name, i), m.done, 1'b0);
         tick();
      end
`ifdef PISO_PARITY_EN
      chk($sformatf("%s_par_valid", name), m.ser_valid, 1'b1);
      chk($sformatf("%s_par_bit", name), m.ser_out, par);
      chk($sformatf("%s_par_done", name), m.done, 1'b0);
      tick();
`else
      if (par === 1'bx) begin
         $display("note: unexpected parity argument");
      end
`endif
      chk($sformatf("%s_done", name), m.done, 1'b1);
      chk($sformatf("%s_end_valid", name), m.ser_valid, 1'b0);
      chk($sformatf("%s_end_out", name), m.ser_out, 1'b0);
      chk($sformatf("%s_end_busy", name), m.busy, 1'b0);
      chk($sformatf("%s_end_lready", name), m.load_ready, 1'b1);
   endtask

   initial begin
      logic [7:0] seq;
      logic       exp_bit;
      int         k;
      int         n_xfer;

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      m.load_valid = 1'b0;
      m.load_data  = 8'h00;
      m.ser_ready  = 1'b1;
      l.load_valid = 1'b0;
      l.load_data  = 8'h00;
      l.ser_ready  = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_lready", m.load_ready, 1'b1);
      chk("rst_valid", m.ser_valid, 1'b0);
      chk("rst_out", m.ser_out, 1'b0);
      chk("rst_busy", m.busy, 1'b0);
      chk("rst_done", m.done, 1'b0);
      rst = 1'b0;

      // Word A5, MSB first, continuous ready; load_data changed after load
      m.load_valid = 1'b1;
      m.load_data  = 8'hA5;
      tick();
      m.load_valid = 1'b0;
      m.load_data  = 8'h00;
      shift_word_m("a5", 8'b1010_0101, 1'b0, 1'b0);
      tick();
      chk("a5_done_pulse", m.done, 1'b0);

      // Abort by reset after 3 bits of 5A, then load 0F
      m.load_valid = 1'b1;
      m.load_data  = 8'h5A;
      tick();
      m.load_valid = 1'b0;
      seq = 8'b0101_1010;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("5a_bit%0d", i), m.ser_out, seq[7-i]);
         tick();
      end
      rst = 1'b1;
      #1;
      chk("abort_valid", m.ser_valid, 1'b0);
      chk("abort_lready", m.load_ready, 1'b1);
      chk("abort_busy", m.busy, 1'b0);
      chk("abort_out", m.ser_out, 1'b0);
      tick();
      chk("abort_nodone", m.done, 1'b0);
      rst = 1'b0;
      m.load_valid = 1'b1;
      m.load_data  = 8'h0F;
      tick();
      m.load_valid = 1'b0;
      chk("post_rst_nodone", m.done, 1'b0);
      shift_word_m("0f", 8'b0000_1111, 1'b0, 1'b0);
      tick();

      // Back-to-back: FF then 00 with load_valid held high
      m.load_valid = 1'b1;
      m.load_data  = 8'hFF;
      tick();
      m.load_data  = 8'h00;
      shift_word_m("ff", 8'b1111_1111, 1'b0, 1'b0);
      tick();
      m.load_valid = 1'b0;
      shift_word_m("b2b00", 8'b0000_0000, 1'b0, 1'b0);
      tick();

      // Load attempt during SHIFT is refused and stream unaffected
      m.load_valid = 1'b1;
      m.load_data  = 8'h3C;
      tick();
      m.load_valid = 1'b0;
      shift_word_m("3c", 8'b0011_1100, 1'b0, 1'b1);
      tick();
      chk("3c_no_reload", m.busy, 1'b0);

      // C3 with ready pattern 1,0,0,1,0,0,...
      m.load_valid = 1'b1;
      m.load_data  = 8'hC3;
      tick();
      m.load_valid = 1'b0;
      seq = 8'b1100_0011;
`ifdef PISO_PARITY_EN
      n_xfer = 9;
`else
      n_xfer = 8;
`endif
      k = 0;
      for (int c = 0; c < 40 && k < n_xfer; c++) begin
         m.ser_ready = (c % 3 == 0);
         exp_bit = (k < 8) ? seq[7-k] : 1'b0;
         chk($sformatf("c3_valid_c%0d", c), m.ser_valid, 1'b1);
         chk($sformatf("c3_bit_c%0d", c), m.ser_out, exp_bit);
         chk($sformatf("c3_done_c%0d", c), m.done, 1'b0);
         tick();
         if (m.ser_ready) k++;
      end
      m.ser_ready = 1'b1;
      chk("c3_xfer_count", k, n_xfer);
      chk("c3_done", m.done, 1'b1);
      chk("c3_end_valid", m.ser_valid, 1'b0);
      tick();
      chk("c3_done_pulse", m.done, 1'b0);

      // LSB-first instance: 01 -> 1 then seven 0s, parity 1
      l.load_valid = 1'b1;
      l.load_data  = 8'h01;
      tick();
      l.load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("lsb_valid%0d", i), l.ser_valid, 1'b1);
         chk($sformatf("lsb_bit%0d", i), l.ser_out, (i == 0) ? 1'b1 : 1'b0);
         tick();
      end
`ifdef PISO_PARITY_EN
      chk("lsb_par_bit", l.ser_out, 1'b1);
      chk("lsb_par_valid", l.ser_valid, 1'b1);
      tick();
`endif
      chk("lsb_done", l.done, 1'b1);
      chk("lsb_end_valid", l.ser_valid, 1'b0);
      tick();
      chk("lsb_done_pulse", l.done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
